fifo_dual_port_ram: RTL and testbench
=====================================

# fifo_dual_port_ram

Generic true-dual-port memory used as the storage element of the FWFT FIFOs. The block-RAM FIFO variant uses it with latency 1; the LUT-RAM FIFO variant uses it with latency 0 (asynchronous read). Port A is the FIFO write side and port B the FIFO read side. Both ports are fully symmetric read/write ports. FIFO pointer, flag and fall-through logic live outside this block.

## Interface
- `width`, default 32: data width of both ports.
- `widthad`, default 4: address width of both ports.
- `numwords`, default 16: valid words, addresses 0..numwords-1; must satisfy numwords ≤ 2^widthad.
- `latency`, default 1: read latency in cycles, 0, 1 or 2.
- `ramstyle`, default "": synthesis hint only ("", "block", "distributed", "registers"); no functional effect.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears the output registers only.
- `clken`  in  1  clock enable for writes and output registers.
- `address_a`  in  widthad  port A address.
- `wren_a`  in  1  port A write enable.
- `data_a`  in  width  port A write data.
- `q_a`  out  width  port A read data.
- `address_b`  in  widthad  port B address.
- `wren_b`  in  1  port B write enable.
- `data_b`  in  width  port B write data.
- `q_b`  out  width  port B read data.

## Operation
- **Write.** On a rising `clk` with `clken`=1 and `wren_x`=1, mem[address_x] <= data_x.
- **Out-of-range writes.** A write with address ≥ numwords is ignored.
- **Read, latency 0.** q_x = mem[address_x] combinationally. It is not affected by `clken` or `reset`.
- **Read, latency 1.** On each enabled edge, q_x <= mem[address_x].
- **Read, latency 2.** Latency 1 plus one extra enabled output register stage.
- **Out-of-range reads.** A read with address ≥ numwords returns all zeros.
- **Read-during-write, same or other port, same address, latency ≥ 1.** Read-first: q shows the old contents, and the new data is visible on the next read.
- **Dual write to the same address in one cycle.** Port A wins.
- **Memory contents.** Never reset, so that RAM inference is preserved. Contents are undefined after power-up (simulation: X).
- **`clken`=0.** No writes occur and all output registers hold their value.

## Timing
- **Reset values.** With latency ≥ 1, q_a = q_b = 0 while `reset` is asserted, asynchronously, in every pipeline stage. With latency 0 the outputs follow memory.
- **Reset mid-operation.** The output pipeline clears; memory contents and any write in the same cycle as the reset deassertion are unaffected.
- **Latency 0.** A write at edge N is visible on q immediately after edge N.
- **Latency 1.** With the address presented before edge N, data appears after edge N.
- **Latency 2.** Data appears after edge N+1.
- **Stalled cycles.** Cycles with `clken`=0 do not count toward latency.
- **Throughput.** One read and one write per port per enabled cycle, with no stalls.

## Configuration
- Macro `FIFO_RAM_CHECK_EN`, simulation-only checks.
- **Defined:** on each rising edge, report an error and `$finish` if either of these occurs:
  - a write is enabled with address ≥ numwords;
  - both ports write the same address in the same cycle.
- **Defined, elaboration time:** also report an error if numwords > 2^widthad or if latency is not in {0, 1, 2}.
- **Undefined:** no checks. Out-of-range writes are silently dropped and port A silently wins collisions.

## Structure
- **Package `fifo_ram_pkg`:**
  - latency constants LAT_ASYNC=0, LAT_REG=1, LAT_REG2=2;
  - ramstyle string constants;
  - function `in_range(addr, numwords)`.
- **Sub-module `fifo_ram_out_pipe`:**
  - parameterized by width and latency;
  - handles clken gating and async reset;
  - bypassed when latency = 0;
  - instantiated once per port.
- The memory array, the write logic and the collision priority sit in the top level.

## Test plan
- **Reset.** Latency 1, write 0xA5 at address 3 via port A, reset asserted mid-cycle → q_a = q_b = 0 immediately. After release, reading address 3 on B returns 0xA5 one cycle later.
- **Basic read.** Latency 1, write 0x11 at address 0 then 0x22 at address 1 on A; read addresses 0 and 1 on B on back-to-back cycles → q_b = 0x11 then 0x22, each one cycle after its address.
- **Asynchronous read.** Latency 0, write 0x7 at address 5 on edge N while address_b = 5 → q_b = 0x7 right after edge N, with no further edge needed.
- **Read-during-write.** Latency 1, address 2 holds 0x1; A writes 0x9 to address 2 while B reads address 2 → q_b = 0x1. The next cycle's read gives 0x9.
- **Clock enable and wrap-around.** numwords = 12, widthad = 4, `clken`=0 during a write to address 4 → address 4 is unchanged and q holds. A write to address 13 is dropped; reading address 13 returns 0.
- **Collision and checks.** A writes 0x3 and B writes 0x5 to address 6 in the same cycle with `FIFO_RAM_CHECK_EN` undefined → reading address 6 returns 0x3. With the macro defined, the simulation reports an error and finishes.

Source files
------------

// File: rtl/fifo_ram_pkg.sv
// rtl/fifo_ram_pkg.sv - shared constants and helpers for the FIFO dual-port RAM
//
// Purpose: read-latency constants, ramstyle hint strings and the address
// range check shared by the RAM top level and its output pipeline.
// Ports: none (package).
package fifo_ram_pkg;

  // Read latency choices
  localparam int LAT_ASYNC = 0;  // combinational read (LUT-RAM FIFO)
  localparam int LAT_REG   = 1;  // one output register (block-RAM FIFO)
  localparam int LAT_REG2  = 2;  // two output registers

  // ramstyle synthesis hints; they never change behaviour
  localparam string RS_AUTO        = "";
  localparam string RS_BLOCK       = "block";
  localparam string RS_DISTRIBUTED = "distributed";
  localparam string RS_REGISTERS   = "registers";

  // True when addr names a real word of a numwords-deep memory.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned numwords);
    return addr < numwords;
  endfunction

endpackage

// File: rtl/fifo_dual_port_ram_if.sv
// rtl/fifo_dual_port_ram_if.sv - port A / port B bus of the FIFO dual-port RAM
//
// Purpose: bundles the clock enable and both symmetric RAM ports.
// Signals: clken; address_a, wren_a, data_a, q_a; address_b, wren_b, data_b, q_b.
// Modports: master drives addresses/data/enables and reads q_*;
//           slave (the RAM) is the reverse.
interface fifo_dual_port_ram_if #(
  parameter int width   = 32,
  parameter int widthad = 4
);
  logic               clken;
  logic [widthad-1:0] address_a;
  logic               wren_a;
  logic [width-1:0]   data_a;
  logic [width-1:0]   q_a;
  logic [widthad-1:0] address_b;
  logic               wren_b;
  logic [width-1:0]   data_b;
  logic [width-1:0]   q_b;

  modport master (
    output clken, address_a, wren_a, data_a, address_b, wren_b, data_b,
    input  q_a, q_b
  );

  modport slave (
    input  clken, address_a, wren_a, data_a, address_b, wren_b, data_b,
    output q_a, q_b
  );
endinterface

// File: rtl/fifo_ram_out_pipe.sv
// rtl/fifo_ram_out_pipe.sv - read-data output pipeline for one RAM port
//
// Purpose: 0, 1 or 2 clock-enabled output register stages with asynchronous
// active-high clear. Latency 0 is a straight wire.
// Ports: clk, reset (async, active-high), clken (stage enable),
//        d (raw read data), q (port read data).
module fifo_ram_out_pipe
  import fifo_ram_pkg::*;
#(
  parameter int width   = 32,
  parameter int latency = LAT_REG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  generate
    if (latency == LAT_ASYNC) begin : g_bypass
      // Asynchronous read ignores clock, enable and reset entirely.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, clken};
      assign q = d;
    end else begin : g_reg
      logic [width-1:0] stage1;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage1 <= '0;
        end else if (clken) begin
          stage1 <= d;
        end
      end

      if (latency == LAT_REG2) begin : g_two
        logic [width-1:0] stage2;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            stage2 <= '0;
          end else if (clken) begin
            stage2 <= stage1;
          end
        end

        assign q = stage2;
      end else begin : g_one
        assign q = stage1;
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_dual_port_ram.sv
// rtl/fifo_dual_port_ram.sv - true dual-port RAM used as FIFO storage
//
// Purpose: numwords x width memory with two symmetric read/write ports and a
// configurable read latency (0, 1 or 2). Out-of-range writes are dropped,
// out-of-range reads return zero, reads are read-first, and port A wins a
// same-address double write. Memory contents are never reset.
// Ports: clk; reset (async, active-high, clears output registers only);
//        bus (slave modport): clken, address_a/wren_a/data_a/q_a,
//        address_b/wren_b/data_b/q_b.
// Optional: define FIFO_RAM_CHECK_EN for simulation-only checks on
//           out-of-range writes, write collisions and bad parameters.
module fifo_dual_port_ram
  import fifo_ram_pkg::*;
#(
  parameter int    width    = 32,
  parameter int    widthad  = 4,
  parameter int    numwords = 16,
  parameter int    latency  = LAT_REG,
  parameter string ramstyle = RS_AUTO
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_dual_port_ram_if.slave  bus
);

  logic [width-1:0] mem [numwords];

  logic             ok_a;
  logic             ok_b;
  logic [width-1:0] rd_a;
  logic [width-1:0] rd_b;

  assign ok_a = in_range(32'(bus.address_a), numwords);
  assign ok_b = in_range(32'(bus.address_b), numwords);

  // Port B is written first so that port A's assignment lands last and
  // takes priority when both ports target the same word.
  always_ff @(posedge clk) begin
    if (bus.clken) begin
      if (bus.wren_b && ok_b) begin
        mem[bus.address_b] <= bus.data_b;
      end
      if (bus.wren_a && ok_a) begin
        mem[bus.address_a] <= bus.data_a;
      end
    end
  end

  // Raw read: sampled by the output pipeline before this edge's write lands,
  // which gives read-first behaviour for latency >= 1.
  always_comb begin
    rd_a = '0;
    if (ok_a) begin
      rd_a = mem[bus.address_a];
    end
  end

  always_comb begin
    rd_b = '0;
    if (ok_b) begin
      rd_b = mem[bus.address_b];
    end
  end

  fifo_ram_out_pipe #(
    .width   (width),
    .latency (latency)
  ) u_pipe_a (
    .clk   (clk),
    .reset (reset),
    .clken (bus.clken),
    .d     (rd_a),
    .q     (bus.q_a)
  );

  fifo_ram_out_pipe #(
    .width   (width),
    .latency (latency)
  ) u_pipe_b (
    .clk   (clk),
    .reset (reset),
    .clken (bus.clken),
    .d     (rd_b),
    .q     (bus.q_b)
  );

`ifdef FIFO_RAM_CHECK_EN
  initial begin
    if (numwords > (1 << widthad)) begin
      $error("fifo_dual_port_ram: numwords %0d exceeds 2**widthad", numwords);
    end
    if (latency != LAT_ASYNC && latency != LAT_REG && latency != LAT_REG2) begin
      $error("fifo_dual_port_ram: unsupported latency %0d", latency);
    end
  end

  always @(posedge clk) begin
    if (bus.clken) begin
      if ((bus.wren_a && !ok_a) || (bus.wren_b && !ok_b)) begin
        $error("fifo_dual_port_ram: write to out-of-range address");
        $finish;
      end
      if (bus.wren_a && bus.wren_b && bus.address_a == bus.address_b) begin
        $error("fifo_dual_port_ram: both ports write address %0d", bus.address_a);
        $finish;
      end
    end
  end
`else
  // Without the checks, out-of-range writes are dropped and port A silently
  // wins collisions, both handled by the write logic above.
`endif

endmodule

// File: tb/tb_fifo_dual_port_ram.sv
// tb/tb_fifo_dual_port_ram.sv - self-checking bench for fifo_dual_port_ram
module tb_fifo_dual_port_ram;
  localparam int W  = 32;
  localparam int AW = 4;
  localparam int NW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clken = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic          wren_a = 1'b0;
  logic [W-1:0]  data_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic          wren_b = 1'b0;
  logic [W-1:0]  data_b = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // One DUT per latency (index = latency), all fed the same stimulus.
  fifo_dual_port_ram_if #(.width(W), .widthad(AW)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].clken     = clken;
    assign bus[g].address_a = addr_a;
    assign bus[g].wren_a    = wren_a;
    assign bus[g].data_a    = data_a;
    assign bus[g].address_b = addr_b;
    assign bus[g].wren_b    = wren_b;
    assign bus[g].data_b    = data_b;

    fifo_dual_port_ram #(
      .width(W), .widthad(AW), .numwords(NW), .latency(g), .ramstyle("")
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  // Reference model: word array plus the expected output of one and two
  // enabled cycles ago.
  logic [W-1:0] mdl [NW];
  logic [W-1:0] e1a = '0, e1b = '0, e2a = '0, e2b = '0;

  function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
    if (a < NW) return mdl[a];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg();
    chk("lat1_q_a", bus[1].q_a, e1a);
    chk("lat1_q_b", bus[1].q_b, e1b);
    chk("lat2_q_a", bus[2].q_a, e2a);
    chk("lat2_q_b", bus[2].q_b, e2b);
  endtask

  task automatic chk_all();
    chk("lat0_q_a", bus[0].q_a, rd(addr_a));
    chk("lat0_q_b", bus[0].q_b, rd(addr_b));
    chk_reg();
  endtask

  task automatic set_reset(input logic r);
    reset = r;
    if (r) begin
      e1a = '0; e1b = '0; e2a = '0; e2b = '0;
    end
  endtask

  task automatic cycle(input bit do_chk);
    logic [W-1:0] ra, rb;
    @(posedge clk);
    if (clken) begin
      ra = rd(addr_a);
      rb = rd(addr_b);
      if (!reset) begin
        e2a = e1a; e2b = e1b; e1a = ra; e1b = rb;
      end
      if (wren_b && addr_b < NW) mdl[addr_b] = data_b;
      if (wren_a && addr_a < NW) mdl[addr_a] = data_a;
    end
    #1;
    if (do_chk) chk_all();
  endtask

  task automatic drive(input logic ce, input logic [AW-1:0] aa, input logic wa,
                       input logic [W-1:0] da, input logic [AW-1:0] ab,
                       input logic wb, input logic [W-1:0] db);
    clken = ce; addr_a = aa; wren_a = wa; data_a = da;
    addr_b = ab; wren_b = wb; data_b = db;
  endtask

  initial begin
    // Reset state of the registered outputs, before any edge.
    #3;
    chk_reg();
    @(posedge clk); #1;
    chk_reg();
    set_reset(1'b0);

    // Fill every word; reads point out of range so nothing undefined is seen.
    for (int i = 0; i < NW; i++) begin
      drive(1, AW'(i), 1, $urandom, 4'd13, 0, '0);
      cycle(0);
    end
    drive(1, 4'd13, 0, '0, 4'd13, 0, '0);
    cycle(0);
    cycle(1);

    // Basic read: 0x11 @0, 0x22 @1, then read them back-to-back on B.
    drive(1, 4'd0, 1, 32'h11, 4'd13, 0, '0); cycle(1);
    drive(1, 4'd1, 1, 32'h22, 4'd13, 0, '0); cycle(1);
    drive(1, 4'd13, 0, '0, 4'd0, 0, '0);     cycle(1);
    chk("basic_q_b_0x11", bus[1].q_b, 32'h11);
    drive(1, 4'd13, 0, '0, 4'd1, 0, '0);     cycle(1);
    chk("basic_q_b_0x22", bus[1].q_b, 32'h22);

    // Async read: write 0x7 @5 while B watches 5.
    drive(1, 4'd5, 1, 32'h7, 4'd5, 0, '0);   cycle(1);
    chk("async_q_b_0x7", bus[0].q_b, 32'h7);

    // Reset mid-operation: write 0xA5 @3, then assert reset mid-cycle.
    drive(1, 4'd3, 1, 32'hA5, 4'd3, 0, '0);  cycle(1);
    #2;
    set_reset(1'b1);
    #1;
    chk_all();
    chk("reset_lat1_q_a", bus[1].q_a, '0);
    drive(1, 4'd13, 0, '0, 4'd3, 0, '0);     cycle(1);
    set_reset(1'b0);
    cycle(1);
    chk("reset_after_q_b_0xA5", bus[1].q_b, 32'hA5);

    // Read-during-write: 0x1 @2, then A writes 0x9 while B reads 2.
    drive(1, 4'd2, 1, 32'h1, 4'd13, 0, '0);  cycle(1);
    drive(1, 4'd2, 1, 32'h9, 4'd2, 0, '0);   cycle(1);
    chk("rdw_old_0x1", bus[1].q_b, 32'h1);
    drive(1, 4'd13, 0, '0, 4'd2, 0, '0);     cycle(1);
    chk("rdw_new_0x9", bus[1].q_b, 32'h9);

    // Clock enable low: write to 4 ignored, outputs hold.
    drive(1, 4'd4, 0, '0, 4'd4, 0, '0);      cycle(1);
    drive(0, 4'd4, 1, 32'hDEAD, 4'd0, 0, '0); cycle(1);
    drive(1, 4'd13, 0, '0, 4'd4, 0, '0);     cycle(1);

    // Out-of-range write to 13 dropped, read of 13 is zero.
    drive(1, 4'd13, 1, 32'hBEEF, 4'd13, 0, '0); cycle(1);
    drive(1, 4'd13, 0, '0, 4'd13, 0, '0);    cycle(1);
    chk("oor_read_zero", bus[1].q_b, '0);

    // Collision at 6: port A wins.
    drive(1, 4'd6, 1, 32'h3, 4'd6, 1, 32'h5); cycle(1);
    drive(1, 4'd13, 0, '0, 4'd6, 0, '0);     cycle(1);
    chk("collision_a_wins", bus[1].q_b, 32'h3);

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 4) != 0), AW'($urandom_range(0, 13)),
            $urandom_range(0, 1), $urandom, AW'($urandom_range(0, 13)),
            $urandom_range(0, 1), $urandom);
      set_reset($urandom_range(0, 24) == 0);
      cycle(1);
    end
    set_reset(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
